// File: rtl/inst_stats_counter_pkg.sv
// Shared opcode map, instruction classes and FSM state for the instruction statistics block.
// Latency: n/a (types, constants and a combinational classifier only).
// Backpressure: n/a.
package inst_stats_counter_pkg;

  // Opcode field is retire_inst[31:26]
  localparam logic [5:0] ADD_OP  = 6'b000000;
  localparam logic [5:0] ADDI_OP = 6'b000001;
  localparam logic [5:0] SUB_OP  = 6'b000010;
  localparam logic [5:0] SUBI_OP = 6'b000011;
  localparam logic [5:0] MUL_OP  = 6'b000100;
  localparam logic [5:0] MULI_OP = 6'b000101;
  localparam logic [5:0] OR_OP   = 6'b000110;
  localparam logic [5:0] ORI_OP  = 6'b000111;
  localparam logic [5:0] AND_OP  = 6'b001000;
  localparam logic [5:0] ANDI_OP = 6'b001001;
  localparam logic [5:0] XOR_OP  = 6'b001010;
  localparam logic [5:0] XORI_OP = 6'b001011;
  localparam logic [5:0] LDW_OP  = 6'b001100;
  localparam logic [5:0] STW_OP  = 6'b001101;
  localparam logic [5:0] BZ_OP   = 6'b001110;
  localparam logic [5:0] BEQ_OP  = 6'b001111;
  localparam logic [5:0] JR_OP   = 6'b010000;
  localparam logic [5:0] HALT_OP = 6'b010001;

  typedef enum logic [2:0] {
    ARITH   = 3'd0,
    LOGIC   = 3'd1,
    MEM     = 3'd2,
    CTRL    = 3'd3,
    ILLEGAL = 3'd4
  } inst_class_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  // Opcodes are allocated in contiguous class ranges, so the upper bound of each range decides the class
  function automatic inst_class_t classify(input logic [5:0] op);
    inst_class_t cls;
    if (op <= MULI_OP)      cls = ARITH;
    else if (op <= XORI_OP) cls = LOGIC;
    else if (op <= STW_OP)  cls = MEM;
    else if (op <= HALT_OP) cls = CTRL;
    else                    cls = ILLEGAL;
    return cls;
  endfunction

endpackage

// File: rtl/inst_stats_counter_sat_counter.sv
// Saturating up-counter: counts inc pulses, sticks at all-ones, freezes while hold is high.
// Latency: 1 cycle from inc to count.
// Backpressure: none; hold simply freezes the value.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         hold,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next value: step by one unless frozen or already at all-ones
  always_comb begin
    count_d = count_q;
    if (!hold && inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register with synchronous clear
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/inst_stats_counter.sv
// Retired-instruction class, stall and cycle statistics; freezes once HALT retires.
// Latency: 1 cycle from retire/stall edge to counter outputs.
// Backpressure: none; every input is sampled each cycle while running, ignored once halted.
module inst_stats_counter
  import inst_stats_counter_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int STALL_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               retire_valid,
  input  logic [31:0]        retire_inst,
  input  logic               stall_raw,
  input  logic               stall_fwd,
  output logic [CNT_W-1:0]   arith_inst_cnt,
  output logic [CNT_W-1:0]   logic_inst_cnt,
  output logic [CNT_W-1:0]   mem_inst_cnt,
  output logic [CNT_W-1:0]   ctrl_inst_cnt,
  output logic [STALL_W-1:0] stall_wo_forewarding,
  output logic [STALL_W-1:0] stall_w_forewarding,
  output logic [STALL_W-1:0] cycle_cnt,
  output logic               halted,
  output logic               illegal_op
);

  state_t      state_q;
  state_t      state_d;
  logic        run;
  logic [5:0]  opcode;
  inst_class_t inst_class;
  logic        arith_inc;
  logic        logic_inc;
  logic        mem_inc;
  logic        ctrl_inc;
  logic        illegal_q;
  logic        illegal_d;
  logic        unused_operand_bits;

  assign opcode     = retire_inst[31:26];
  assign inst_class = classify(opcode);
  // Only the opcode matters here; operand fields are deliberately dropped
  assign unused_operand_bits = ^retire_inst[25:0];

  // FSM state register; reset always returns to RUN
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Next state: a retiring HALT moves to HALTED, which only reset leaves
  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN && retire_valid && opcode == HALT_OP) begin
      state_d = ST_HALTED;
    end
  end

  // FSM outputs: counting enabled only in RUN (the HALT edge itself still counts)
  always_comb begin
    run    = (state_q == ST_RUN);
    halted = (state_q == ST_HALTED);
  end

  // One-hot class increment for the retiring instruction; illegal opcodes hit none
  always_comb begin
    arith_inc = retire_valid && (inst_class == ARITH);
    logic_inc = retire_valid && (inst_class == LOGIC);
    mem_inc   = retire_valid && (inst_class == MEM);
    ctrl_inc  = retire_valid && (inst_class == CTRL);
    illegal_d = illegal_q | (run && retire_valid && (inst_class == ILLEGAL));
  end

  // Sticky illegal-opcode flag
  always_ff @(posedge clk) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= illegal_d;
  end

  assign illegal_op = illegal_q;

  sat_counter #(.W(CNT_W)) u_arith_cnt (
    .clk(clk), .reset(reset), .inc(arith_inc), .hold(halted), .count(arith_inst_cnt)
  );
  sat_counter #(.W(CNT_W)) u_logic_cnt (
    .clk(clk), .reset(reset), .inc(logic_inc), .hold(halted), .count(logic_inst_cnt)
  );
  sat_counter #(.W(CNT_W)) u_mem_cnt (
    .clk(clk), .reset(reset), .inc(mem_inc), .hold(halted), .count(mem_inst_cnt)
  );
  sat_counter #(.W(CNT_W)) u_ctrl_cnt (
    .clk(clk), .reset(reset), .inc(ctrl_inc), .hold(halted), .count(ctrl_inst_cnt)
  );
  sat_counter #(.W(STALL_W)) u_stall_raw_cnt (
    .clk(clk), .reset(reset), .inc(stall_raw), .hold(halted), .count(stall_wo_forewarding)
  );
  sat_counter #(.W(STALL_W)) u_stall_fwd_cnt (
    .clk(clk), .reset(reset), .inc(stall_fwd), .hold(halted), .count(stall_w_forewarding)
  );
  sat_counter #(.W(STALL_W)) u_cycle_cnt (
    .clk(clk), .reset(reset), .inc(1'b1), .hold(halted), .count(cycle_cnt)
  );

endmodule

// File: tb/tb_inst_stats_counter.sv
// Directed bench: two instances (default width and CNT_W=4) driven by the same stimulus.
// Inputs change 1 time unit after each rising edge; outputs are sampled at that same point.
module tb_inst_stats_counter;
  import inst_stats_counter_pkg::*;

  logic        clk;
  logic        reset;
  logic        retire_valid;
  logic [31:0] retire_inst;
  logic        stall_raw;
  logic        stall_fwd;

  logic [15:0] arith_a, logic_a, mem_a, ctrl_a;
  logic [31:0] swo_a, sw_a, cyc_a;
  logic        halted_a, illegal_a;

  logic [3:0]  arith_b, logic_b, mem_b, ctrl_b;
  logic [31:0] swo_b, sw_b, cyc_b;
  logic        halted_b, illegal_b;

  int n_pass = 0;
  int n_total = 0;

  inst_stats_counter dut (
    .clk(clk), .reset(reset), .retire_valid(retire_valid), .retire_inst(retire_inst),
    .stall_raw(stall_raw), .stall_fwd(stall_fwd),
    .arith_inst_cnt(arith_a), .logic_inst_cnt(logic_a), .mem_inst_cnt(mem_a),
    .ctrl_inst_cnt(ctrl_a), .stall_wo_forewarding(swo_a), .stall_w_forewarding(sw_a),
    .cycle_cnt(cyc_a), .halted(halted_a), .illegal_op(illegal_a)
  );

  inst_stats_counter #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .retire_valid(retire_valid), .retire_inst(retire_inst),
    .stall_raw(stall_raw), .stall_fwd(stall_fwd),
    .arith_inst_cnt(arith_b), .logic_inst_cnt(logic_b), .mem_inst_cnt(mem_b),
    .ctrl_inst_cnt(ctrl_b), .stall_wo_forewarding(swo_b), .stall_w_forewarding(sw_b),
    .cycle_cnt(cyc_b), .halted(halted_b), .illegal_op(illegal_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running, expected finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic retire(input logic [5:0] op);
    retire_valid = 1'b1;
    retire_inst  = {op, 26'h2A5A5A5};
    tick();
    retire_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; retire_valid = 1'b0; retire_inst = '0; stall_raw = 1'b0; stall_fwd = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_arith", 32'(arith_a), 0);
    chk("rst_ctrl", 32'(ctrl_a), 0);
    chk("rst_cycle", cyc_a, 0);
    chk("rst_halted", 32'(halted_a), 0);
    chk("rst_illegal", 32'(illegal_a), 0);

    // Class decode, latency one edge
    retire(ADD_OP);
    chk("add_latency", 32'(arith_a), 1);
    retire(ORI_OP);
    retire(LDW_OP);
    retire(STW_OP);
    retire(BEQ_OP);
    chk("mix_arith", 32'(arith_a), 1);
    chk("mix_logic", 32'(logic_a), 1);
    chk("mix_mem", 32'(mem_a), 2);
    chk("mix_ctrl", 32'(ctrl_a), 1);
    chk("mix_halted", 32'(halted_a), 0);

    // retire_inst ignored without retire_valid
    retire_inst = {ADD_OP, 26'h0};
    tick();
    chk("novalid_arith", 32'(arith_a), 1);
    chk("cycle_6", cyc_a, 6);

    // Overlapping stalls: raw for 5 cycles, fwd on cycles 2 and 3
    for (int i = 0; i < 5; i++) begin
      stall_raw = 1'b1;
      stall_fwd = (i == 1 || i == 2);
      tick();
    end
    stall_raw = 1'b0; stall_fwd = 1'b0;
    chk("stall_raw5", swo_a, 5);
    chk("stall_fwd2", sw_a, 2);
    chk("cycle_11", cyc_a, 11);

    // Illegal opcode: flag only, no counter change, no halt
    retire(6'b111111);
    chk("ill_flag", 32'(illegal_a), 1);
    chk("ill_arith", 32'(arith_a), 1);
    chk("ill_logic", 32'(logic_a), 1);
    chk("ill_mem", 32'(mem_a), 2);
    chk("ill_ctrl", 32'(ctrl_a), 1);
    chk("ill_halted", 32'(halted_a), 0);
    retire(ADD_OP);
    chk("ill_still_run", 32'(arith_a), 2);
    chk("ill_sticky", 32'(illegal_a), 1);

    // 20 ADDs: wide counter keeps counting, 4-bit counter saturates
    for (int i = 0; i < 20; i++) retire(ADD_OP);
    chk("sat_wide", 32'(arith_a), 22);
    chk("sat_4bit", 32'(arith_b), 15);
    chk("cycle_33", cyc_a, 33);

    // HALT edge with both stalls: counted, then everything freezes
    stall_raw = 1'b1; stall_fwd = 1'b1;
    retire(HALT_OP);
    stall_fwd = 1'b0;
    chk("halt_ctrl", 32'(ctrl_a), 2);
    chk("halt_flag", 32'(halted_a), 1);
    chk("halt_edge_raw", swo_a, 6);
    chk("halt_edge_fwd", sw_a, 3);
    chk("halt_edge_cycle", cyc_a, 34);
    for (int i = 0; i < 3; i++) retire(ADD_OP);
    stall_raw = 1'b0;
    chk("frozen_arith", 32'(arith_a), 22);
    chk("frozen_raw", swo_a, 6);
    chk("frozen_cycle", cyc_a, 34);
    chk("frozen_ctrl", 32'(ctrl_a), 2);
    chk("frozen_halted", 32'(halted_a), 1);

    // One-cycle reset in HALTED while other inputs are active
    reset = 1'b1; retire_valid = 1'b1; retire_inst = {ADD_OP, 26'h0}; stall_raw = 1'b1; stall_fwd = 1'b1;
    tick();
    reset = 1'b0; retire_valid = 1'b0; stall_raw = 1'b0; stall_fwd = 1'b0;
    chk("rr_arith", 32'(arith_a), 0);
    chk("rr_mem", 32'(mem_a), 0);
    chk("rr_raw", swo_a, 0);
    chk("rr_fwd", sw_a, 0);
    chk("rr_cycle", cyc_a, 0);
    chk("rr_halted", 32'(halted_a), 0);
    chk("rr_illegal", 32'(illegal_a), 0);
    chk("rr_4bit_arith", 32'(arith_b), 0);
    retire(ADD_OP);
    chk("rr_add_arith", 32'(arith_a), 1);
    chk("rr_add_cycle", cyc_a, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
